// File: rtl/wino_out_xform.sv
`default_nettype none
// ============================================================================
// Module   : wino_out_xform
// Purpose  : Winograd F(2,3) output (inverse) transform, O = A^T * Y * A,
//            with A^T = [1 1 1 0 ; 0 1 -1 -1]. One shared adder tree handles
//            one Y column per cycle in PASS1 (4 cycles) and one T row per
//            cycle in PASS2 (2 cycles). The result is then held in OUT until
//            it is accepted.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/y_tile  - 4x4 Y tile in, Y[0][0] in the MSBs
//            out_valid/out_ready/o_tile - 2x2 O tile out, O[0][0] in the MSBs
// Revision : 1.0 - initial release
// ============================================================================
module wino_out_xform #(
  parameter int W  = 8,
  parameter int OW = W + 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*W-1:0] y_tile,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*OW-1:0] o_tile
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [16*W-1:0]   y_q;
  logic signed [W+1:0] t0_q [4];
  logic signed [W+1:0] t1_q [4];
  logic signed [OW-1:0] o_q [4];

  // Unpack the captured tile into a 4x4 view of signed elements.
  logic signed [W-1:0] y_e [4][4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign y_e[r][c] = y_q[(15-(4*r+c))*W +: W];
    end
  end

  // PASS1 column adder: signed assignment sign-extends to W+2.
  logic signed [W+1:0] yc0, yc1, yc2, yc3;
  logic signed [W+1:0] t0_sum, t1_sum;

  always_comb begin
    yc0    = y_e[0][cnt_q];
    yc1    = y_e[1][cnt_q];
    yc2    = y_e[2][cnt_q];
    yc3    = y_e[3][cnt_q];
    t0_sum = yc0 + yc1 + yc2;
    t1_sum = yc1 - yc2 - yc3;
  end

  // PASS2 row adder: the same structure applied to row cnt_q[0] of T.
  logic signed [OW-1:0] tr0, tr1, tr2, tr3;
  logic signed [OW-1:0] o0_sum, o1_sum;

  always_comb begin
    tr0    = cnt_q[0] ? t1_q[0] : t0_q[0];
    tr1    = cnt_q[0] ? t1_q[1] : t0_q[1];
    tr2    = cnt_q[0] ? t1_q[2] : t0_q[2];
    tr3    = cnt_q[0] ? t1_q[3] : t0_q[3];
    o0_sum = tr0 + tr1 + tr2;
    o1_sum = tr1 - tr2 - tr3;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = PASS1;
          cnt_d   = 2'd0;
        end
      end
      PASS1: begin
        if (cnt_q == 2'd3) begin
          state_d = PASS2;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      PASS2: begin
        if (cnt_q == 2'd1) begin
          state_d = OUT;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers. o_q is only written in PASS2, so the previous result
  // stays visible on o_tile until the next tile overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      for (int k = 0; k < 4; k++) begin
        t0_q[k] <= '0;
        t1_q[k] <= '0;
        o_q[k]  <= '0;
      end
    end else begin
      if (state_q == IDLE && in_valid) begin
        y_q <= y_tile;
      end
      if (state_q == PASS1) begin
        t0_q[cnt_q] <= t0_sum;
        t1_q[cnt_q] <= t1_sum;
      end
      if (state_q == PASS2) begin
        if (cnt_q[0]) begin
          o_q[2] <= o0_sum;
          o_q[3] <= o1_sum;
        end else begin
          o_q[0] <= o0_sum;
          o_q[1] <= o1_sum;
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign o_tile    = {o_q[0], o_q[1], o_q[2], o_q[3]};

endmodule
`default_nettype wire
